// File: rtl/uartb_pkg.sv
// Shared definitions for the burst-capable UART receive path: FSM encoding,
// oversampling ratio, configuration-bus field positions and word packing helper.
package uartb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE     = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int CFG_MODE_BIT   = 31;
  localparam int CFG_DIV_MSB    = 8;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  // Writes byte b into little-endian lane 'lane' of word w.
  function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[lane*8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/uartb_rx_burst_if.sv
// CPU/line-side bundle of the burst UART receiver: serial input, shared config
// write, read strobe and the received-word status outputs.
interface uartb_rx_burst_if;

  logic        rxd;
  logic [31:0] d;
  logic        wrbaud;
  logic        rd;
  logic [31:0] q;
  logic [2:0]  nbytes;
  logic        dv;
  logic        ferr;
  logic        ovf;
  logic        busy;

  modport master (
    output rxd, d, wrbaud, rd,
    input  q, nbytes, dv, ferr, ovf, busy
  );

  modport slave (
    input  rxd, d, wrbaud, rd,
    output q, nbytes, dv, ferr, ovf, busy
  );

endinterface

// File: rtl/uartb_baud_tick.sv
// Oversampling tick generator: one-clk tick every (div+1) clocks, registered.
// restart zeroes the phase so the first tick lands div+1 clocks later.
module uartb_baud_tick #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] div,
  input  logic         restart,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uartb_rx_burst.sv
// 8N1 receiver, 16x oversampled; byte (normal) or 4-byte little-endian word (burst) to q, dv one clk after stop sample.
// No backpressure: completion while dv is set raises ovf and drops data. UARTB_RX_TIMEOUT_EN adds idle flush of partial bursts.
module uartb_rx_burst
  import uartb_pkg::*;
#(
  parameter logic [CFG_DIV_MSB:0] DIV_RESET = 9'd7
`ifdef UARTB_RX_TIMEOUT_EN
  , parameter int TIMEOUT_BITS = 40
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  uartb_rx_burst_if.slave  bus
);

  logic                 rxd_s1, rxd_s2, rxd_d;
  logic [CFG_DIV_MSB:0] divider, div_active;
  logic                 mode;
  rx_state_t            state;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 acc_vld;
  logic [7:0]           acc_byte;
  logic                 fe_vld;
  logic [1:0]           idx;
  logic [31:0]          lane_buf;
  logic [31:0]          q_r;
  logic [2:0]           nbytes_r;
  logic                 dv_r, ferr_r, ovf_r;
  logic                 tick, start_det, mode_chg, flush;
  logic                 cmpl, lane_wr;
  logic [31:0]          cmpl_word;
  logic [2:0]           cmpl_n;
  logic                 cfg_unused;

  assign cfg_unused = ^bus.d[CFG_MODE_BIT-1:CFG_DIV_MSB+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= bus.rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign start_det = (state == IDLE) && rxd_d && !rxd_s2;
  assign mode_chg  = bus.wrbaud && (bus.d[CFG_MODE_BIT] != mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider    <= DIV_RESET;
      mode       <= MODE_NORMAL;
      div_active <= DIV_RESET;
    end else begin
      if (bus.wrbaud) begin
        divider <= bus.d[CFG_DIV_MSB:0];
        mode    <= bus.d[CFG_MODE_BIT];
      end
      // Frame timing is frozen at start-bit detection; config writes apply to the next frame.
      if (start_det) begin
        div_active <= divider;
      end
    end
  end

  uartb_baud_tick #(
    .W(CFG_DIV_MSB + 1)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div_active),
    .restart (start_det),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      acc_vld  <= 1'b0;
      acc_byte <= '0;
      fe_vld   <= 1'b0;
    end else begin
      acc_vld <= 1'b0;
      fe_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE/2 - 1)) begin
              tick_cnt <= '0;
              state    <= rxd_s2 ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              shreg   <= {rxd_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              state <= IDLE;
              if (rxd_s2) begin
                acc_vld  <= 1'b1;
                acc_byte <= shreg;
              end else begin
                fe_vld <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UARTB_RX_TIMEOUT_EN
  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_TICKS + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      flush  <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (state != IDLE || mode != MODE_BURST || idx == 2'd0 || acc_vld) begin
        to_cnt <= '0;
      end else if (tick) begin
        if (to_cnt == TO_W'(TO_TICKS - 1)) begin
          to_cnt <= '0;
          flush  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign flush = 1'b0;
`endif

  // A mode change in the same cycle discards whatever the receiver hands over.
  always_comb begin
    cmpl      = 1'b0;
    lane_wr   = 1'b0;
    cmpl_word = '0;
    cmpl_n    = '0;
    if (!mode_chg) begin
      if (acc_vld) begin
        if (mode == MODE_NORMAL) begin
          cmpl      = 1'b1;
          cmpl_word = {24'h0, acc_byte};
          cmpl_n    = 3'd1;
        end else if (idx == 2'(BYTES_PER_WORD - 1)) begin
          cmpl      = 1'b1;
          cmpl_word = lane_insert(lane_buf, idx, acc_byte);
          cmpl_n    = 3'(BYTES_PER_WORD);
        end else begin
          lane_wr = 1'b1;
        end
      end else if (flush) begin
        cmpl      = 1'b1;
        cmpl_word = lane_buf;
        cmpl_n    = {1'b0, idx};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      lane_buf <= '0;
      q_r      <= '0;
      nbytes_r <= '0;
      dv_r     <= 1'b0;
      ferr_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (mode_chg || cmpl) begin
        idx      <= '0;
        lane_buf <= '0;
      end else if (lane_wr) begin
        lane_buf <= lane_insert(lane_buf, idx, acc_byte);
        idx      <= idx + 1'b1;
      end

      // A read landing with a completion frees the register, so the new word is taken.
      if (cmpl) begin
        if (!(dv_r && !bus.rd)) begin
          q_r      <= cmpl_word;
          nbytes_r <= cmpl_n;
          dv_r     <= 1'b1;
        end
      end else if (bus.rd) begin
        dv_r <= 1'b0;
      end

      if (cmpl && dv_r && !bus.rd) begin
        ovf_r <= 1'b1;
      end else if (bus.rd) begin
        ovf_r <= 1'b0;
      end

      if (fe_vld) begin
        ferr_r <= 1'b1;
      end else if (bus.rd) begin
        ferr_r <= 1'b0;
      end
    end
  end

  assign bus.q      = q_r;
  assign bus.nbytes = nbytes_r;
  assign bus.dv     = dv_r;
  assign bus.ferr   = ferr_r;
  assign bus.ovf    = ovf_r;
  assign bus.busy   = (state != IDLE) || (idx != 2'd0);

endmodule

// File: tb/tb_uartb_rx_burst.sv
// Directed bench for uartb_rx_burst: 8N1 frames at 128 clk/bit, table of normal-mode
// frames plus hand sequences for burst packing, overrun/read races, glitches, mode change and reset.
module tb_uartb_rx_burst;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  uartb_rx_burst_if u_if();

  uartb_rx_burst dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dat;
    logic        stop;
    logic        rd_after;
    logic [31:0] q;
    logic [2:0]  nb;
    logic        dv;
    logic        ferr;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_cfg(input logic [31:0] v);
    @(negedge clk);
    u_if.d      = v;
    u_if.wrbaud = 1'b1;
    @(negedge clk);
    u_if.wrbaud = 1'b0;
  endtask

  task automatic pulse_rd();
    u_if.rd = 1'b1;
    @(negedge clk);
    u_if.rd = 1'b0;
  endtask

  task automatic frame_head(input logic [7:0] dat);
    u_if.rxd = 1'b0;
    clks(128);
    for (int i = 0; i < 8; i++) begin
      u_if.rxd = dat[i];
      clks(128);
    end
  endtask

  task automatic send_byte(input logic [7:0] dat, input logic stop);
    frame_head(dat);
    u_if.rxd = stop;
    clks(128);
    u_if.rxd = 1'b1;
    clks(16);
  endtask

  // Polls until the receiver leaves the frame; returns on the negedge right after the stop sample.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (u_if.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (u_if.busy) begin
      fails++;
      $display("FAIL %s: busy still 1 after %0d clk, expected 0", name, n);
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted before summary (%0d tests so far)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b0, 32'h0000_0041, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 32'h0000_005A, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h42, 1'b1, 1'b1, 32'h0000_005A, 3'd1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h41, 1'b1, 1'b0, 32'h0000_0041, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h42, 1'b1, 1'b0, 32'h0000_0041, 3'd1, 1'b1, 1'b0, 1'b1};

    rst_n       = 1'b0;
    u_if.rxd    = 1'b1;
    u_if.d      = '0;
    u_if.wrbaud = 1'b0;
    u_if.rd     = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(1000);
    chk("rst_q", u_if.q, 32'h0);
    chk("rst_dv", u_if.dv, 1'b0);
    chk("rst_ferr", u_if.ferr, 1'b0);
    chk("rst_ovf", u_if.ovf, 1'b0);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_nbytes", u_if.nbytes, 3'd0);

    // Normal mode: dv must appear exactly one clk after the stop sample.
    wr_cfg(32'h0000_0007);
    frame_head(8'h41);
    u_if.rxd = 1'b1;
    wait_idle("a_stop");
    chk("a_dv_at_stop", u_if.dv, 1'b0);
    @(negedge clk);
    chk("a_dv", u_if.dv, 1'b1);
    chk("a_q", u_if.q, 32'h0000_0041);
    chk("a_nbytes", u_if.nbytes, 3'd1);
    clks(128);
    pulse_rd();
    chk("a_dv_after_rd", u_if.dv, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].dat, vecs[i].stop);
      chk($sformatf("v%0d_q", i), u_if.q, vecs[i].q);
      chk($sformatf("v%0d_nbytes", i), u_if.nbytes, vecs[i].nb);
      chk($sformatf("v%0d_dv", i), u_if.dv, vecs[i].dv);
      chk($sformatf("v%0d_ferr", i), u_if.ferr, vecs[i].ferr);
      chk($sformatf("v%0d_ovf", i), u_if.ovf, vecs[i].ovf);
      if (vecs[i].rd_after) pulse_rd();
    end

    // rd coincident with the completion edge: new byte taken, ovf cleared.
    frame_head(8'h43);
    u_if.rxd = 1'b1;
    wait_idle("c_stop");
    chk("c_ovf_before", u_if.ovf, 1'b1);
    u_if.rd = 1'b1;
    @(negedge clk);
    u_if.rd = 1'b0;
    chk("c_q", u_if.q, 32'h0000_0043);
    chk("c_dv", u_if.dv, 1'b1);
    chk("c_ovf", u_if.ovf, 1'b0);
    chk("c_nbytes", u_if.nbytes, 3'd1);
    clks(128);
    pulse_rd();
    chk("c_dv_after_rd", u_if.dv, 1'b0);

    // Short low glitch: start sample sees high line, back to idle silently.
    u_if.rxd = 1'b0;
    clks(20);
    chk("g_busy_during", u_if.busy, 1'b1);
    clks(20);
    u_if.rxd = 1'b1;
    clks(200);
    chk("g_busy", u_if.busy, 1'b0);
    chk("g_dv", u_if.dv, 1'b0);
    chk("g_ferr", u_if.ferr, 1'b0);

    // Burst mode: four bytes packed little-endian.
    wr_cfg(32'h8000_0007);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    chk("b_dv_partial", u_if.dv, 1'b0);
    chk("b_busy_partial", u_if.busy, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("b_q", u_if.q, 32'h4443_4241);
    chk("b_nbytes", u_if.nbytes, 3'd4);
    chk("b_dv", u_if.dv, 1'b1);
    chk("b_busy", u_if.busy, 1'b0);
    pulse_rd();

    // Mode change discards a partial burst.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("m_busy_partial", u_if.busy, 1'b1);
    wr_cfg(32'h0000_0007);
    chk("m_busy", u_if.busy, 1'b0);
    chk("m_dv", u_if.dv, 1'b0);
    wr_cfg(32'h8000_0007);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h0A, 1'b1);
    chk("m_q", u_if.q, 32'h0A0B_0C0D);
    chk("m_nbytes", u_if.nbytes, 3'd4);
    pulse_rd();

    // Partial burst followed by a long idle line.
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    clks(4000);
    chk("t_dv_early", u_if.dv, 1'b0);
    clks(1400);
`ifdef UARTB_RX_TIMEOUT_EN
    chk("t_dv", u_if.dv, 1'b1);
    chk("t_nbytes", u_if.nbytes, 3'd2);
    chk("t_q", u_if.q, 32'h0000_B2A1);
    chk("t_busy", u_if.busy, 1'b0);
`else
    chk("t_dv_held", u_if.dv, 1'b0);
    chk("t_busy_held", u_if.busy, 1'b1);
`endif

    // Asynchronous reset in the middle of a frame.
    u_if.rxd = 1'b0;
    clks(300);
    chk("r_busy_before", u_if.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r_busy", u_if.busy, 1'b0);
    chk("r_dv", u_if.dv, 1'b0);
    chk("r_q", u_if.q, 32'h0);
    chk("r_nbytes", u_if.nbytes, 3'd0);
    u_if.rxd = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(20);
    chk("r_busy_after", u_if.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
